rf_access_ctrl: RTL and testbench
=================================

# rf_access_ctrl

Two-requester access controller for the 8-entry × 8-bit register file. It arbitrates between two requesters (e.g. ALU writeback and an external load/debug port), sequences each accepted operation onto the register file's single shared address/write port, and returns read data with a valid pulse. It sits directly in front of the register file and is the only block that drives that file's address, data and write-enable lines.

## Interface
- DATA_W, 8, register data width
- ADDR_W, 3, register index width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  per-requester request; bit i = requester i
- we  in  2  per-requester op type: 1 write, 0 read
- addr1  in  2*ADDR_W  requester i write/read-port-1 index in bits [i*ADDR_W +: ADDR_W]
- addr2  in  2*ADDR_W  requester i read-port-2 index, same packing
- wdata  in  2*DATA_W  requester i write data, same packing
- gnt  out  2  one-cycle grant pulse for the accepted requester
- rvalid  out  2  one-cycle read-data-valid pulse for the requester
- rdata1, rdata2  out  DATA_W each  read results, held until the next read completes
- busy  out  1  high whenever state is not IDLE
- rf_op1, rf_op2  out  ADDR_W each  register file indices
- rf_data  out  DATA_W  register file write data
- rf_en_write  out  1  register file write enable
- rf_out1, rf_out2  in  DATA_W each  register file read data

## Operation
- FSM states: IDLE, ACCESS, CAPTURE.
- IDLE: if any req bit is high, the arbiter picks winner w. At the next edge the controller latches we[w], addr1[w], addr2[w] and wdata[w], and moves to ACCESS. With no req, it stays in IDLE.
- ACCESS: gnt[w]=1. rf_op1=addr1, rf_op2=addr2.
  - Write: rf_en_write=1 and rf_data=wdata; the file writes at the end of ACCESS. Next state is IDLE.
  - Read: rf_en_write=0. Next state is CAPTURE.
- CAPTURE: op lines are held. At the end of CAPTURE, rdata1<=rf_out1 and rdata2<=rf_out2. rvalid[w]=1 in the following cycle, which is IDLE. Next state is IDLE.
- In IDLE, rf_op1 and rf_op2 hold their last values, rf_en_write=0, and rf_data=0.
- Handshake: a requester holds req and its fields stable until it sees gnt, then drops req at the same edge. If req is still high in IDLE after gnt, it counts as a new request.
- Arbitration: see Configuration. The last-grant pointer updates only on a grant.
- Simultaneous events: rvalid in IDLE may coincide with a new arbitration decision. This is allowed, and rdata stays stable during it.
- Reset mid-operation: asynchronously returns to IDLE and clears all outputs. A write in progress in ACCESS is aborted with no register file update, because rf_en_write falls before the edge.
- Reset values: gnt=0, rvalid=0, rdata1=rdata2=0, busy=0, rf_op1=rf_op2=0, rf_data=0, rf_en_write=0, last-grant pointer=1 (so requester 0 wins first).

## Timing
- The request is sampled at edge T0. gnt is high in cycle T0+1.
- Write: the register file updates at edge T0+2. The controller is back in IDLE at T0+2. Throughput is one write per 2 cycles.
- Read: capture happens at edge T0+3, and rvalid/rdata are visible in cycle T0+3. Throughput is one read per 3 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from req to gnt.

## Configuration
- RFC_RR_EN defined: round-robin arbitration. On simultaneous requests, the requester not granted last wins.
- RFC_RR_EN undefined: fixed priority, requester 0 always wins, and the pointer logic is removed.

## Structure
- Package rfc_pkg holds:
  - the state enum (IDLE, ACCESS, CAPTURE)
  - the DATA_W and ADDR_W defaults
  - the NREQ=2 constant
  - the latched-request struct (we, addr1, addr2, wdata)
- Sub-module rfc_arbiter: 2-way arbiter with the last-grant pointer and an RFC_RR_EN-dependent policy. Outputs are a one-hot winner and a valid flag.

## Test plan
- After reset, requester 0 writes 8'hA5 to r3 → gnt=2'b01 at T0+1, rf_en_write=1 with rf_op1=3 for exactly one cycle. Then requester 1 reads addr1=3, addr2=0 → rvalid=2'b10 with rdata1=8'hA5, rdata2=8'h00.
- Both requesters request continuously, with RFC_RR_EN defined → grants alternate 01,10,01,10. With RFC_RR_EN undefined → grants are 01 every time.
- Back-to-back writes r1=8'h11, r2=8'h22, then a read of r1/r2 → rdata1=8'h11, rdata2=8'h22. busy is high except in IDLE cycles.
- Read rvalid cycle coincides with a new req → rdata is unchanged that cycle and the new gnt follows one cycle later.
- Assert rst_n=0 during ACCESS of a write of 8'hFF to r5 → rf_en_write drops immediately. A subsequent read of r5 returns 8'h00, and all outputs show reset values.
- No requests for 20 cycles → gnt, rvalid, rf_en_write and busy stay 0.

Source files
------------

// File: rtl/rfc_pkg.sv
// Shared types and constants for the register-file access controller.
package rfc_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned NREQ       = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr1;
    logic [DEF_ADDR_W-1:0] addr2;
    logic [DEF_DATA_W-1:0] wdata;
  } lat_req_t;

endpackage

// File: rtl/rfc_arbiter.sv
// Two-way request arbiter. RFC_RR_EN selects round-robin with a last-grant
// pointer; otherwise requester 0 has fixed priority and no pointer state exists.
module rfc_arbiter
  import rfc_pkg::*;
(
`ifdef RFC_RR_EN
  input  logic            clk,
  input  logic            rst_n,
  input  logic            arb_en,
`endif
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] win_oh,
  output logic            win_vld
);

`ifdef RFC_RR_EN
  // last_q holds the index of the most recently granted requester.
  logic last_q, last_d;

  always_comb begin
    win_oh  = req;
    win_vld = |req;
    if (req == 2'b11) begin
      win_oh = last_q ? 2'b01 : 2'b10;
    end
    last_d = last_q;
    if (arb_en && win_vld) begin
      last_d = win_oh[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    win_vld = |req;
    win_oh  = req[0] ? 2'b01 : {req[1], 1'b0};
  end
`endif

endmodule

// File: rtl/rf_access_ctrl.sv
// Two-requester access controller for the 8x8 register file: arbitrates,
// sequences one op onto the shared file port, returns read data. Macro: RFC_RR_EN.
module rf_access_ctrl
  import rfc_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*ADDR_W-1:0] addr1,
  input  logic [NREQ*ADDR_W-1:0] addr2,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata1,
  output logic [DATA_W-1:0]      rdata2,
  output logic                   busy,
  output logic [ADDR_W-1:0]      rf_op1,
  output logic [ADDR_W-1:0]      rf_op2,
  output logic [DATA_W-1:0]      rf_data,
  output logic                   rf_en_write,
  input  logic [DATA_W-1:0]      rf_out1,
  input  logic [DATA_W-1:0]      rf_out2
);

  state_e            state_q, state_d;
  lat_req_t          lat_q, lat_d;
  logic [NREQ-1:0]   win_q, win_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [DATA_W-1:0] rdata2_q, rdata2_d;

  logic [NREQ-1:0]   win_oh;
  logic              win_vld;
  logic              arb_en;

  assign arb_en = (state_q == IDLE);

  rfc_arbiter u_arbiter (
`ifdef RFC_RR_EN
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_en  (arb_en),
`endif
    .req     (req),
    .win_oh  (win_oh),
    .win_vld (win_vld)
  );

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    win_d    = win_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    rvalid_d = '0;

    case (state_q)
      IDLE: begin
        if (arb_en && win_vld) begin
          win_d   = win_oh;
          state_d = ACCESS;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
              lat_d.we    = we[i];
              lat_d.addr1 = addr1[i*ADDR_W +: ADDR_W];
              lat_d.addr2 = addr2[i*ADDR_W +: ADDR_W];
              lat_d.wdata = wdata[i*DATA_W +: DATA_W];
            end
          end
        end
      end
      ACCESS: begin
        state_d = lat_q.we ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        rdata1_d = rf_out1;
        rdata2_d = rf_out2;
        rvalid_d = win_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      win_q    <= '0;
      rvalid_q <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      win_q    <= win_d;
      rvalid_q <= rvalid_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
    end
  end

  // Port-facing outputs are decoded from state and latched fields only, so an
  // asynchronous reset drops rf_en_write before the file can commit a write.
  assign gnt         = (state_q == ACCESS) ? win_q : '0;
  assign rf_en_write = (state_q == ACCESS) && lat_q.we;
  assign rf_data     = rf_en_write ? lat_q.wdata : '0;
  assign rf_op1      = lat_q.addr1;
  assign rf_op2      = lat_q.addr2;
  assign busy        = (state_q != IDLE);
  assign rvalid      = rvalid_q;
  assign rdata1      = rdata1_q;
  assign rdata2      = rdata2_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a behavioural 8x8 register file.
// Grant-order expectations follow RFC_RR_EN.
module tb_rf_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [5:0]  addr1;
  logic [5:0]  addr2;
  logic [15:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [7:0]  rdata1;
  logic [7:0]  rdata2;
  logic        busy;
  logic [2:0]  rf_op1;
  logic [2:0]  rf_op2;
  logic [7:0]  rf_data;
  logic        rf_en_write;
  logic [7:0]  rf_out1;
  logic [7:0]  rf_out2;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rf_mem [8];

  rf_access_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .we          (we),
    .addr1       (addr1),
    .addr2       (addr2),
    .wdata       (wdata),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata1      (rdata1),
    .rdata2      (rdata2),
    .busy        (busy),
    .rf_op1      (rf_op1),
    .rf_op2      (rf_op2),
    .rf_data     (rf_data),
    .rf_en_write (rf_en_write),
    .rf_out1     (rf_out1),
    .rf_out2     (rf_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 8; i++) rf_mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (rf_en_write) rf_mem[rf_op1] <= rf_data;
  end

  assign rf_out1 = rf_mem[rf_op1];
  assign rf_out2 = rf_mem[rf_op2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned i, input logic w, input logic [2:0] a1,
                       input logic [2:0] a2, input logic [7:0] d);
    we[i]            = w;
    addr1[i*3 +: 3]  = a1;
    addr2[i*3 +: 3]  = a2;
    wdata[i*8 +: 8]  = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},     {14'd0, gnt},     16'h0);
    chk({tag, "_rvalid"},  {14'd0, rvalid},  16'h0);
    chk({tag, "_rdata1"},  {8'd0, rdata1},   16'h0);
    chk({tag, "_rdata2"},  {8'd0, rdata2},   16'h0);
    chk({tag, "_busy"},    {15'd0, busy},    16'h0);
    chk({tag, "_rf_op1"},  {13'd0, rf_op1},  16'h0);
    chk({tag, "_rf_op2"},  {13'd0, rf_op2},  16'h0);
    chk({tag, "_rf_data"}, {8'd0, rf_data},  16'h0);
    chk({tag, "_rf_en"},   {15'd0, rf_en_write}, 16'h0);
  endtask

  logic [1:0] exp_gnt [4];

  initial begin
`ifdef RFC_RR_EN
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    rst_n = 1'b0;
    req   = '0;
    we    = '0;
    addr1 = '0;
    addr2 = '0;
    wdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Requester 0 writes A5 to r3
    drive(0, 1'b1, 3'd3, 3'd0, 8'hA5);
    req = 2'b01;
    tick();
    chk("w_gnt",     {14'd0, gnt},     16'h1);
    chk("w_en",      {15'd0, rf_en_write}, 16'h1);
    chk("w_op1",     {13'd0, rf_op1},  16'h3);
    chk("w_data",    {8'd0, rf_data},  16'hA5);
    chk("w_busy",    {15'd0, busy},    16'h1);
    req = 2'b00;
    tick();
    chk("w_en_off",  {15'd0, rf_en_write}, 16'h0);
    chk("w_gnt_off", {14'd0, gnt},     16'h0);
    chk("w_busy_off",{15'd0, busy},    16'h0);
    chk("w_data_off",{8'd0, rf_data},  16'h0);
    chk("w_op1_hold",{13'd0, rf_op1},  16'h3);

    // Requester 1 reads r3 / r0
    drive(1, 1'b0, 3'd3, 3'd0, 8'h00);
    req = 2'b10;
    tick();
    chk("r_gnt",     {14'd0, gnt},     16'h2);
    chk("r_en",      {15'd0, rf_en_write}, 16'h0);
    req = 2'b00;
    tick();
    chk("r_cap_busy",{15'd0, busy},    16'h1);
    chk("r_cap_gnt", {14'd0, gnt},     16'h0);
    chk("r_cap_rv",  {14'd0, rvalid},  16'h0);
    tick();
    chk("r_rvalid",  {14'd0, rvalid},  16'h2);
    chk("r_rdata1",  {8'd0, rdata1},   16'hA5);
    chk("r_rdata2",  {8'd0, rdata2},   16'h00);
    chk("r_busy",    {15'd0, busy},    16'h0);
    tick();
    chk("r_rv_off",  {14'd0, rvalid},  16'h0);
    chk("r_hold1",   {8'd0, rdata1},   16'hA5);

    // Both requesters write continuously
    drive(0, 1'b1, 3'd6, 3'd0, 8'h66);
    drive(1, 1'b1, 3'd7, 3'd0, 8'h77);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("arb_gnt",  {14'd0, gnt},  {14'd0, exp_gnt[k]});
      chk("arb_busy", {15'd0, busy}, 16'h1);
      if (k == 3) req = 2'b00;
      tick();
      chk("arb_idle_gnt",  {14'd0, gnt},  16'h0);
      chk("arb_idle_busy", {15'd0, busy}, 16'h0);
    end

    // Back-to-back writes r1=11, r2=22, then read r1/r2
    drive(0, 1'b1, 3'd1, 3'd0, 8'h11);
    req = 2'b01;
    tick();
    chk("b2b_gnt1",  {14'd0, gnt},     16'h1);
    chk("b2b_op1a",  {13'd0, rf_op1},  16'h1);
    chk("b2b_data1", {8'd0, rf_data},  16'h11);
    drive(0, 1'b1, 3'd2, 3'd0, 8'h22);
    tick();
    chk("b2b_idle_busy", {15'd0, busy}, 16'h0);
    chk("b2b_idle_en",   {15'd0, rf_en_write}, 16'h0);
    tick();
    chk("b2b_gnt2",  {14'd0, gnt},     16'h1);
    chk("b2b_op1b",  {13'd0, rf_op1},  16'h2);
    chk("b2b_data2", {8'd0, rf_data},  16'h22);
    drive(0, 1'b0, 3'd1, 3'd2, 8'h00);
    tick();
    chk("b2b_idle2_busy", {15'd0, busy}, 16'h0);
    tick();
    chk("b2b_rgnt",  {14'd0, gnt},     16'h1);
    chk("b2b_ren",   {15'd0, rf_en_write}, 16'h0);
    req = 2'b00;
    tick();
    chk("b2b_cap_busy", {15'd0, busy}, 16'h1);
    // New request raised so it is visible during the rvalid cycle
    drive(1, 1'b0, 3'd6, 3'd3, 8'h00);
    req = 2'b10;
    tick();
    chk("b2b_rvalid", {14'd0, rvalid}, 16'h1);
    chk("b2b_rdata1", {8'd0, rdata1},  16'h11);
    chk("b2b_rdata2", {8'd0, rdata2},  16'h22);
    chk("coin_gnt0",  {14'd0, gnt},    16'h0);
    chk("coin_busy",  {15'd0, busy},   16'h0);
    tick();
    chk("coin_gnt",    {14'd0, gnt},    16'h2);
    chk("coin_rv_off", {14'd0, rvalid}, 16'h0);
    chk("coin_hold1",  {8'd0, rdata1},  16'h11);
    chk("coin_hold2",  {8'd0, rdata2},  16'h22);
    req = 2'b00;
    tick();
    tick();
    chk("coin_rvalid", {14'd0, rvalid}, 16'h2);
    chk("coin_rdata1", {8'd0, rdata1},  16'h66);
    chk("coin_rdata2", {8'd0, rdata2},  16'hA5);

    // Reset asserted during ACCESS of a write FF to r5
    drive(0, 1'b1, 3'd5, 3'd0, 8'hFF);
    req = 2'b01;
    tick();
    chk("rw_en", {15'd0, rf_en_write}, 16'h1);
    chk("rw_op1", {13'd0, rf_op1}, 16'h5);
    req = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    tick();
    chk_reset_vals("held_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(0, 1'b0, 3'd5, 3'd3, 8'h00);
    req = 2'b01;
    tick();
    chk("pr_gnt", {14'd0, gnt}, 16'h1);
    req = 2'b00;
    tick();
    tick();
    chk("pr_rvalid", {14'd0, rvalid}, 16'h1);
    chk("pr_rdata1", {8'd0, rdata1},  16'h00);
    chk("pr_rdata2", {8'd0, rdata2},  16'hA5);

    // Quiet period
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("idle_gnt",    {14'd0, gnt},    16'h0);
      chk("idle_rvalid", {14'd0, rvalid}, 16'h0);
      chk("idle_en",     {15'd0, rf_en_write}, 16'h0);
      chk("idle_busy",   {15'd0, busy},   16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
